// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC bus scheduler.
//  - NREG:     number of RTC registers scanned into the display digits
//  - phase_e:  bus transaction phase encoding used by rtc_bus_phy
//  - reg_addr: scan index (0..NREG-1) -> RTC register address
package rtc_pkg;

  localparam int NREG = 9;

  typedef enum logic [2:0] {
    PH_IDLE  = 3'd0,
    PH_ADDR  = 3'd1,
    PH_TURN  = 3'd2,
    PH_DATA  = 3'd3,
    PH_RECOV = 3'd4
  } phase_e;

  // Scan order: sec, min, hr, day, mon, yr, timer sec, timer min, timer hr.
  function automatic logic [7:0] reg_addr(input logic [3:0] idx);
    case (idx)
      4'd0:    reg_addr = 8'h21;
      4'd1:    reg_addr = 8'h22;
      4'd2:    reg_addr = 8'h23;
      4'd3:    reg_addr = 8'h24;
      4'd4:    reg_addr = 8'h25;
      4'd5:    reg_addr = 8'h26;
      4'd6:    reg_addr = 8'h41;
      4'd7:    reg_addr = 8'h42;
      4'd8:    reg_addr = 8'h43;
      default: reg_addr = 8'h21;
    endcase
  endfunction

endpackage

// File: rtl/rtc_bus_phy.sv
// Single-transaction engine for the RTC multiplexed AD bus.
// A transaction runs ADDR -> TURN -> DATA -> RECOV, PHASE_CYC cycles each.
// Ports:
//  clk, reset        clock, asynchronous active-low reset
//  start             begin a transaction (honoured in IDLE or on the final RECOV cycle)
//  rnw, addr, data   transaction kind (1 = read), register address, write data
//  done              high on the final RECOV cycle
//  busy              high from ADDR through RECOV
//  rdata             read value, captured on the last DATA cycle
//  rtc_*             AD bus pins
module rtc_bus_phy
  import rtc_pkg::*;
#(
  parameter int PHASE_CYC = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rnw,
  input  logic [7:0] addr,
  input  logic [7:0] data,
  output logic       done,
  output logic       busy,
  output logic [7:0] rdata,
  input  logic [7:0] rtc_ad_in,
  output logic [7:0] rtc_ad_out,
  output logic       rtc_ad_oe,
  output logic       rtc_cs_n,
  output logic       rtc_rd_n,
  output logic       rtc_wr_n,
  output logic       rtc_a_d
);

  localparam int CW = (PHASE_CYC > 2) ? $clog2(PHASE_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PHASE_CYC - 1);

  phase_e        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          rnw_reg;
  logic [7:0]    addr_reg, data_reg, rdata_reg;
  logic          last;
  logic          accept;

  assign last   = (cnt_reg == CNT_LAST);
  assign done   = (state_reg == PH_RECOV) && last;
  assign busy   = (state_reg != PH_IDLE);
  assign accept = start && ((state_reg == PH_IDLE) || done);
  assign rdata  = rdata_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= PH_IDLE;
      cnt_reg   <= '0;
      rnw_reg   <= 1'b1;
      addr_reg  <= 8'h00;
      data_reg  <= 8'h00;
      rdata_reg <= 8'h00;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        rnw_reg  <= rnw;
        addr_reg <= addr;
        data_reg <= data;
      end
      if ((state_reg == PH_DATA) && last && rnw_reg) begin
        rdata_reg <= rtc_ad_in;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = '0;
    rtc_cs_n   = 1'b1;
    rtc_rd_n   = 1'b1;
    rtc_wr_n   = 1'b1;
    rtc_a_d    = 1'b1;
    rtc_ad_oe  = 1'b0;
    rtc_ad_out = 8'h00;
    if (state_reg != PH_IDLE) begin
      cnt_next = last ? '0 : cnt_reg + CW'(1);
    end
    case (state_reg)
      PH_IDLE: begin
        if (start) state_next = PH_ADDR;
      end
      PH_ADDR: begin
        rtc_cs_n   = 1'b0;
        rtc_a_d    = 1'b0;
        rtc_wr_n   = 1'b0;
        rtc_ad_oe  = 1'b1;
        rtc_ad_out = addr_reg;
        if (last) state_next = PH_TURN;
      end
      PH_TURN: begin
        if (last) state_next = PH_DATA;
      end
      PH_DATA: begin
        rtc_cs_n = 1'b0;
        if (rnw_reg) begin
          rtc_rd_n = 1'b0;
        end else begin
          rtc_wr_n   = 1'b0;
          rtc_ad_oe  = 1'b1;
          rtc_ad_out = data_reg;
        end
        if (last) state_next = PH_RECOV;
      end
      PH_RECOV: begin
        // Chain straight into the next transaction so scans stay back-to-back.
        if (last) state_next = start ? PH_ADDR : PH_IDLE;
      end
      default: state_next = PH_IDLE;
    endcase
  end

endmodule

// File: rtl/rtc_bus_scheduler.sv
// Scans the nine RTC time/date/timer registers into 18 BCD display digits and
// arbitrates that scan against one-shot user writes.
// Ports:
//  clk, reset                 clock, asynchronous active-low reset
//  wr_req/wr_addr/wr_data     user write request (held until wr_ack), address, data
//  wr_ack                     pulse on the final RECOV cycle of the write
//  rtc_ad_in .. rtc_a_d       RTC AD bus pins
//  digits                     byte i = register i (low nibble = digit 2i)
//  scan_done                  pulse when digits update
//  cron_done                  timer registers all zero in the last completed scan
//  busy                       bus transaction in progress
module rtc_bus_scheduler
  import rtc_pkg::*;
#(
  parameter int PHASE_CYC   = 4,
  parameter int SCAN_PERIOD = 5_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_req,
  input  logic [7:0]  wr_addr,
  input  logic [7:0]  wr_data,
  output logic        wr_ack,
  input  logic [7:0]  rtc_ad_in,
  output logic [7:0]  rtc_ad_out,
  output logic        rtc_ad_oe,
  output logic        rtc_cs_n,
  output logic        rtc_rd_n,
  output logic        rtc_wr_n,
  output logic        rtc_a_d,
  output logic [71:0] digits,
  output logic        scan_done,
  output logic        cron_done,
  output logic        busy
);

  localparam int PW = $clog2(SCAN_PERIOD);

  logic [PW-1:0] per_cnt_reg;
  logic          scan_pend_reg, scan_act_reg, cur_wr_reg;
  logic [3:0]    nxt_idx_reg, cur_idx_reg;
  logic [7:0]    shadow_reg [NREG-1];
  logic [71:0]   digits_reg, snap;
  logic          scan_done_reg, cron_done_reg;

  logic       phy_start, phy_done, phy_busy;
  logic [7:0] phy_addr, phy_rdata;
  logic       dec, wr_take, scan_take, new_take, commit, per_wrap;

  // Decisions are made when the bus is idle or on the final RECOV cycle.
  assign dec       = !phy_busy || phy_done;
  // The write in flight is still requesting on its own done cycle; ignore that.
  assign wr_take   = dec && wr_req && !(phy_done && cur_wr_reg);
  assign scan_take = dec && !wr_take && scan_act_reg && (nxt_idx_reg != 4'(NREG));
  assign new_take  = dec && !wr_take && !scan_take && scan_pend_reg;
  // A write accepted on the last read's boundary aborts that scan too.
  assign commit    = phy_done && !cur_wr_reg && (cur_idx_reg == 4'(NREG - 1)) && !wr_take;
  assign per_wrap  = (per_cnt_reg == PW'(SCAN_PERIOD - 1));

  assign phy_start = wr_take || scan_take || new_take;
  assign phy_addr  = wr_take ? wr_addr : reg_addr(scan_take ? nxt_idx_reg : 4'd0);

  // The final register arrives straight from the phy on the commit cycle.
  genvar gi;
  generate
    for (gi = 0; gi < NREG - 1; gi++) begin : g_shadow
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          shadow_reg[gi] <= 8'h00;
        end else if (phy_done && !cur_wr_reg && (cur_idx_reg == 4'(gi))) begin
          shadow_reg[gi] <= phy_rdata;
        end
      end
      assign snap[8*gi +: 8] = shadow_reg[gi];
    end
  endgenerate
  assign snap[71:64] = phy_rdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      per_cnt_reg   <= '0;
      scan_pend_reg <= 1'b0;
      scan_act_reg  <= 1'b0;
      cur_wr_reg    <= 1'b0;
      nxt_idx_reg   <= 4'd0;
      cur_idx_reg   <= 4'd0;
      digits_reg    <= '0;
      scan_done_reg <= 1'b0;
      cron_done_reg <= 1'b0;
    end else begin
      per_cnt_reg   <= per_wrap ? '0 : per_cnt_reg + PW'(1);
      scan_done_reg <= commit;
      if (commit) begin
        digits_reg    <= snap;
        cron_done_reg <= (shadow_reg[6] == 8'h00) && (shadow_reg[7] == 8'h00) &&
                         (phy_rdata == 8'h00);
        scan_act_reg  <= 1'b0;
      end
      if (wr_take) begin
        cur_wr_reg <= 1'b1;
        if (scan_act_reg) nxt_idx_reg <= 4'd0;
      end else if (scan_take) begin
        cur_wr_reg  <= 1'b0;
        cur_idx_reg <= nxt_idx_reg;
        nxt_idx_reg <= nxt_idx_reg + 4'd1;
      end else if (new_take) begin
        cur_wr_reg    <= 1'b0;
        cur_idx_reg   <= 4'd0;
        nxt_idx_reg   <= 4'd1;
        scan_act_reg  <= 1'b1;
        scan_pend_reg <= 1'b0;
      end
      // A wrap on the same cycle a scan starts is a fresh request.
      if (per_wrap) scan_pend_reg <= 1'b1;
    end
  end

  rtc_bus_phy #(.PHASE_CYC(PHASE_CYC)) u_phy (
    .clk        (clk),
    .reset      (reset),
    .start      (phy_start),
    .rnw        (!wr_take),
    .addr       (phy_addr),
    .data       (wr_data),
    .done       (phy_done),
    .busy       (phy_busy),
    .rdata      (phy_rdata),
    .rtc_ad_in  (rtc_ad_in),
    .rtc_ad_out (rtc_ad_out),
    .rtc_ad_oe  (rtc_ad_oe),
    .rtc_cs_n   (rtc_cs_n),
    .rtc_rd_n   (rtc_rd_n),
    .rtc_wr_n   (rtc_wr_n),
    .rtc_a_d    (rtc_a_d)
  );

  assign wr_ack    = phy_done && cur_wr_reg;
  assign busy      = phy_busy;
  assign digits    = digits_reg;
  assign scan_done = scan_done_reg;
  assign cron_done = cron_done_reg;

endmodule
